// File: rtl/axis_frame_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_frame_decoder                                                       |
// | Decodes SYNC/CMD/ADDR/DATA/XOR byte frames into one wide command word.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axis_frame_decoder #(
    parameter int         DATA_BYTES = 4,
    parameter logic [7:0] SYNC       = 8'hA5,
    parameter int         TIMEOUT    = 133000
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [7:0]              idata,
    input  logic                    ivalid,
    output logic                    iready,
    output logic [7:0]              ocmd,
    output logic [7:0]              oaddr,
    output logic [8*DATA_BYTES-1:0] odata,
    output logic                    ovalid,
    input  logic                    oready,
    output logic                    error,
    output logic [7:0]              error_count
);

    localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]    C_TMO_LIMIT = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(DATA_BYTES - 1);

    localparam logic [2:0] ST_HUNT  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;

    logic [2:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              xor_q, xor_d;
    logic [7:0]              cmd_sh_q, cmd_sh_d;
    logic [7:0]              addr_sh_q, addr_sh_d;
    logic [8*DATA_BYTES-1:0] data_sh_q, data_sh_d;
    logic [7:0]              ocmd_q, ocmd_d;
    logic [7:0]              oaddr_q, oaddr_d;
    logic [8*DATA_BYTES-1:0] odata_q, odata_d;
    logic                    ovalid_q, ovalid_d;
    logic                    error_q, error_d;
    logic [7:0]              err_cnt_q, err_cnt_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    w_accept;
    logic                    w_drop;

    // The checksum byte is held off only while the output register is occupied
    // and not draining, so a frame can load in the same cycle one leaves.
    assign iready   = !((state_q == ST_CHECK) && ovalid_q && !oready);
    assign w_accept = ivalid && iready;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        xor_d     = xor_q;
        cmd_sh_d  = cmd_sh_q;
        addr_sh_d = addr_sh_q;
        data_sh_d = data_sh_q;
        ocmd_d    = ocmd_q;
        oaddr_d   = oaddr_q;
        odata_d   = odata_q;
        ovalid_d  = ovalid_q && !oready;
        error_d   = 1'b0;
        err_cnt_d = err_cnt_q;
        tmo_d     = tmo_q;
        w_drop    = 1'b0;

        if (w_accept) begin
            tmo_d = '0;
            case (state_q)
                ST_HUNT: begin
                    if (idata == SYNC) begin
                        xor_d   = 8'h00;
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    cmd_sh_d = idata;
                    xor_d    = xor_q ^ idata;
                    state_d  = ST_ADDR;
                end
                ST_ADDR: begin
                    addr_sh_d = idata;
                    xor_d     = xor_q ^ idata;
                    idx_d     = '0;
                    state_d   = ST_DATA;
                end
                ST_DATA: begin
                    data_sh_d[{idx_q, 3'b000} +: 8] = idata;
                    xor_d = xor_q ^ idata;
                    if (idx_q == C_LAST_IDX) begin
                        state_d = ST_CHECK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (idata == xor_q) begin
                        ocmd_d   = cmd_sh_q;
                        oaddr_d  = addr_sh_q;
                        odata_d  = data_sh_q;
                        ovalid_d = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                    state_d = ST_HUNT;
                end
                default: state_d = ST_HUNT;
            endcase
        end else if ((TIMEOUT != 0) && (state_q != ST_HUNT) && iready) begin
            if (tmo_q == C_TMO_LIMIT) begin
                w_drop  = 1'b1;
                tmo_d   = '0;
                state_d = ST_HUNT;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        if (w_drop) begin
            error_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_HUNT;
            idx_q     <= '0;
            xor_q     <= 8'h00;
            cmd_sh_q  <= 8'h00;
            addr_sh_q <= 8'h00;
            data_sh_q <= '0;
            ocmd_q    <= 8'h00;
            oaddr_q   <= 8'h00;
            odata_q   <= '0;
            ovalid_q  <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= 8'h00;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            xor_q     <= xor_d;
            cmd_sh_q  <= cmd_sh_d;
            addr_sh_q <= addr_sh_d;
            data_sh_q <= data_sh_d;
            ocmd_q    <= ocmd_d;
            oaddr_q   <= oaddr_d;
            odata_q   <= odata_d;
            ovalid_q  <= ovalid_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign ocmd        = ocmd_q;
    assign oaddr       = oaddr_q;
    assign odata       = odata_q;
    assign ovalid      = ovalid_q;
    assign error       = error_q;
    assign error_count = err_cnt_q;

endmodule
`default_nettype wire
